// File: rtl/adler32_calc_pkg.sv
// adler32_calc_pkg: shared FSM encoding and Adler-32 constants
package adler32_calc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [15:0] ADLER_MOD_BASE = 16'd65521;
  localparam logic [31:0] ADLER_INIT = 32'h0000_0001;
endpackage

// File: rtl/adler32_mod_add.sv
// adler32_mod_add: (a_i + b_i) mod ADLER_MOD_BASE for operands already below 2*ADLER_MOD_BASE
//   a_i   in  16  running sum, always < ADLER_MOD_BASE
//   b_i   in  16  addend (zero-extended byte or updated s1)
//   sum_o out 16  reduced sum
module adler32_mod_add
  import adler32_calc_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);
  logic [16:0] t;
  assign t = {1'b0, a_i} + {1'b0, b_i};
  // Both operands are below the modulus, so a single subtract fully reduces t.
  assign sum_o = t >= {1'b0, ADLER_MOD_BASE} ? 16'(t - {1'b0, ADLER_MOD_BASE}) : t[15:0];
endmodule

// File: rtl/adler32_calc.sv
// adler32_calc: Adler-32 checksum engine, one byte per cycle, done pulse one cycle after the last byte
//   clk     in  1   clock
//   rstn    in  1   asynchronous reset, active-high
//   start_i in  1   begin a new checksum (re-initialises sums, aborts a running one)
//   val_i   in  1   dat_i valid
//   dat_i   in  8   input byte
//   lst_i   in  1   with val_i: last byte of the stream
//   busy_o  out 1   high while in RUN
//   done_o  out 1   one-cycle pulse, dat_o final
//   dat_o   out 32  {s2, s1}, held until next start_i
//   cnt_o   out 32  accepted byte count (only when ADLER32_CNT_EN is defined)
module adler32_calc
  import adler32_calc_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic        val_i,
  input  logic [7:0]  dat_i,
  input  logic        lst_i,
  output logic        busy_o,
  output logic        done_o,
`ifdef ADLER32_CNT_EN
  output logic [31:0] cnt_o,
`endif
  output logic [31:0] dat_o
);
  state_e state_q;
  logic [15:0] s1_q, s2_q, s1_d, s2_d;
  logic busy_q, done_q, acc;
  // start_i wins over a byte presented in the same cycle.
  assign acc = state_q == RUN && val_i && !start_i;
  adler32_mod_add u_s1 (.a_i(s1_q), .b_i({8'h00, dat_i}), .sum_o(s1_d));
  adler32_mod_add u_s2 (.a_i(s2_q), .b_i(s1_d), .sum_o(s2_d));
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      state_q <= IDLE;
      s1_q <= ADLER_INIT[15:0];
      s2_q <= ADLER_INIT[31:16];
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      state_q <= RUN;
      s1_q <= ADLER_INIT[15:0];
      s2_q <= ADLER_INIT[31:16];
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (acc) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      if (lst_i) begin
        state_q <= DONE;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else if (state_q == DONE) begin
      state_q <= IDLE;
      done_q <= 1'b0;
    end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign dat_o = {s2_q, s1_q};
`ifdef ADLER32_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or posedge rstn)
    if (rstn) cnt_q <= '0;
    else if (start_i) cnt_q <= '0;
    else if (acc) cnt_q <= cnt_q + 32'd1;
  assign cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_adler32_calc.sv
// tb_adler32_calc: scoreboard bench for adler32_calc
module tb_adler32_calc;
  logic clk = 1'b0, rstn, start_i, val_i, lst_i;
  logic [7:0] dat_i;
  logic busy_o, done_o;
  logic [31:0] dat_o;
`ifdef ADLER32_CNT_EN
  logic [31:0] cnt_o;
  int exp_cnt_q[$];
`endif
  int checks = 0, errors = 0, done_cnt = 0, m_s1, m_s2, d0;
  logic [31:0] exp_q[$];
  logic [7:0] bytes[$];

  adler32_calc dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .val_i(val_i), .dat_i(dat_i), .lst_i(lst_i),
    .busy_o(busy_o), .done_o(done_o),
`ifdef ADLER32_CNT_EN
    .cnt_o(cnt_o),
`endif
    .dat_o(dat_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (done_o) begin
      done_cnt++;
      if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
      else begin
        check("dat_on_done", dat_o, exp_q.pop_front());
`ifdef ADLER32_CNT_EN
        check("cnt_on_done", cnt_o, exp_cnt_q.pop_front());
`endif
      end
    end

  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic l);
    start_i = s; val_i = v; dat_i = d; lst_i = l;
    @(posedge clk); #1;
    start_i = 0; val_i = 0; lst_i = 0;
  endtask

  task automatic load(input string s);
    bytes.delete();
    for (int i = 0; i < s.len(); i++) bytes.push_back(s[i]);
  endtask

  task automatic send(input logic [31:0] exp, input bit gaps, input bit idle_after);
    step(1, 0, 8'h00, 0);
    m_s1 = 1; m_s2 = 0;
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(0, 0, 8'($urandom), 1'($urandom_range(0, 1)));
      if (i == bytes.size() - 1) begin
        exp_q.push_back(exp);
`ifdef ADLER32_CNT_EN
        exp_cnt_q.push_back(bytes.size());
`endif
      end
      step(0, 1, bytes[i], i == bytes.size() - 1);
      m_s1 = (m_s1 + int'(bytes[i])) % 65521;
      m_s2 = (m_s2 + m_s1) % 65521;
      check("dat_per_byte", dat_o, {m_s2[15:0], m_s1[15:0]});
    end
    if (idle_after) begin
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      check("queue_drained", exp_q.size(), 32'd0);
      check("busy_idle", {31'd0, busy_o}, 32'd0);
      check("dat_held", dat_o, exp);
    end
  endtask

  initial begin
    rstn = 1; start_i = 0; val_i = 0; dat_i = 0; lst_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dat", dat_o, 32'h0000_0001);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
`ifdef ADLER32_CNT_EN
    check("rst_cnt", cnt_o, 32'd0);
`endif
    rstn = 0;
    step(0, 1, 8'h55, 1);
    check("idle_ignores_val", dat_o, 32'h0000_0001);
    load("a");
    send(32'h0062_0062, 0, 1);
    load("abc");
    send(32'h024D_0127, 0, 1);
    load("Wikipedia");
    send(32'h11E6_0398, 1, 1);
    bytes.delete();
    repeat (1024) bytes.push_back(8'hFF);
    send(32'h79A6_FC2E, 0, 1);
    d0 = done_cnt;
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h30 + i), 0);
    load("abc");
    send(32'h024D_0127, 0, 1);
    check("abort_done_once", done_cnt - d0, 32'd1);
    d0 = done_cnt;
    load("a");
    send(32'h0062_0062, 0, 0);
    load("abc");
    send(32'h024D_0127, 0, 1);
    check("done_then_start", done_cnt - d0, 32'd2);
    start_i = 1; val_i = 1; dat_i = 8'h10; lst_i = 1;
    @(posedge clk); #1;
    start_i = 0; val_i = 0; lst_i = 0;
    check("start_byte_ignored", dat_o, 32'h0000_0001);
    step(0, 1, 8'h61, 0);
    step(0, 1, 8'h62, 0);
    step(0, 1, 8'h63, 0);
    d0 = done_cnt;
    rstn = 1;
    #1;
    check("midrst_dat", dat_o, 32'h0000_0001);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    rstn = 0;
    step(0, 1, 8'h64, 1);
    check("midrst_no_done", done_cnt - d0, 32'd0);
    check("post_rst_idle", dat_o, 32'h0000_0001);
    load("a");
    send(32'h0062_0062, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
